// File: rtl/sync_fifo_fwft.sv
// First-word-fall-through synchronous FIFO: a block-RAM array whose registered
// read port is the presented head word, so there is no input-to-output bypass.
module sync_fifo_fwft #(
  parameter int ADDR_WIDTH        = 5,
  parameter int DATA_WIDTH        = 32,
  parameter int ALMOST_FULL_LEVEL = (2 ** ADDR_WIDTH) - 4
) (
  input  logic                  i_clock,
  input  logic                  i_reset,
  input  logic                  i_valid,
  output logic                  o_ready,
  input  logic [DATA_WIDTH-1:0] i_data,
  output logic                  o_valid,
  input  logic                  i_ready,
  output logic [DATA_WIDTH-1:0] o_data,
  output logic [ADDR_WIDTH:0]   o_count,
  output logic                  o_almost_full
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0]   C_DEPTH    = (ADDR_WIDTH + 1)'(DEPTH);
  localparam logic [ADDR_WIDTH:0]   C_AF_LEVEL = (ADDR_WIDTH + 1)'(ALMOST_FULL_LEVEL);
  localparam logic [ADDR_WIDTH:0]   C_CNT_ONE  = (ADDR_WIDTH + 1)'(1);
  localparam logic [ADDR_WIDTH-1:0] C_PTR_ONE  = ADDR_WIDTH'(1);

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic [ADDR_WIDTH-1:0] r_wrPtr;
  logic [ADDR_WIDTH-1:0] r_rdPtr;
  logic [ADDR_WIDTH:0]   r_count;
  logic [ADDR_WIDTH:0]   r_ramCount;
  logic [ADDR_WIDTH:0]   w_countNext;
  logic [ADDR_WIDTH:0]   w_ramCountNext;
  logic                  r_outValid;
  logic                  r_almostFull;
  logic [DATA_WIDTH-1:0] r_outData;
  logic                  w_ready;
  logic                  w_write;
  logic                  w_read;
  logic                  w_fetch;

  // r_count covers every held word; r_ramCount only those not yet fetched to the head.
  assign w_ready = !i_reset && (r_count != C_DEPTH);
  assign w_write = i_valid && w_ready;
  assign w_read  = r_outValid && i_ready;
  assign w_fetch = (r_ramCount != '0) && (!r_outValid || w_read);

  always_comb begin
    w_countNext    = r_count;
    w_ramCountNext = r_ramCount;
    if (w_write && !w_read) begin
      w_countNext = r_count + C_CNT_ONE;
    end else if (!w_write && w_read) begin
      w_countNext = r_count - C_CNT_ONE;
    end
    if (w_write && !w_fetch) begin
      w_ramCountNext = r_ramCount + C_CNT_ONE;
    end else if (!w_write && w_fetch) begin
      w_ramCountNext = r_ramCount - C_CNT_ONE;
    end
  end

  always_ff @(posedge i_clock) begin
    if (w_write) begin
      r_mem[r_wrPtr] <= i_data;
    end
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_outData <= '0;
    end else if (w_fetch) begin
      r_outData <= r_mem[r_rdPtr];
    end
  end

  // The head stays valid while stalled; it drops only when consumed with nothing to refill it.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_wrPtr      <= '0;
      r_rdPtr      <= '0;
      r_count      <= '0;
      r_ramCount   <= '0;
      r_outValid   <= 1'b0;
      r_almostFull <= 1'b0;
    end else begin
      r_count      <= w_countNext;
      r_ramCount   <= w_ramCountNext;
      r_almostFull <= (w_countNext >= C_AF_LEVEL);
      if (w_write) begin
        r_wrPtr <= r_wrPtr + C_PTR_ONE;
      end
      if (w_fetch) begin
        r_rdPtr    <= r_rdPtr + C_PTR_ONE;
        r_outValid <= 1'b1;
      end else if (w_read) begin
        r_outValid <= 1'b0;
      end
    end
  end

  assign o_ready       = w_ready;
  assign o_valid       = r_outValid;
  assign o_data        = r_outData;
  assign o_count       = r_count;
  assign o_almost_full = r_almostFull;

endmodule

// File: doc/sync_fifo_fwft.md
SYNC_FIFO_FWFT -- requirements
Module: sync_fifo_fwft

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 5, storage address width; DEPTH = 2**ADDR_WIDTH entries.
REQ-002 SHALL have parameter DATA_WIDTH, default 32, word width in bits.
REQ-003 SHALL have parameter ALMOST_FULL_LEVEL, default DEPTH-4, o_almost_full threshold; legal range 1..DEPTH.
REQ-004 SHALL have port i_clock, input, 1, the single clock; all logic is on its rising edge.
REQ-005 SHALL have port i_reset, input, 1, reset; synchronous and active-high.
REQ-006 SHALL have port i_valid, input, 1, upstream word valid.
REQ-007 SHALL have port o_ready, output, 1, FIFO can accept a word.
REQ-008 SHALL have port i_data, input, DATA_WIDTH, upstream word.
REQ-009 SHALL have port o_valid, output, 1, head word presented.
REQ-010 SHALL have port i_ready, input, 1, downstream consumes the head word.
REQ-011 SHALL have port o_data, output, DATA_WIDTH, head word.
REQ-012 SHALL have port o_count, output, ADDR_WIDTH+1, entries held, including words in flight and the presented head word.
REQ-013 SHALL have port o_almost_full, output, 1, asserted when o_count >= ALMOST_FULL_LEVEL.

Function
REQ-014 Storage SHALL be a simple dual-port RAM array (one write port, one registered read port with 1-cycle latency) inferable as block RAM, plus at most two DATA_WIDTH output/skid registers.
REQ-015 A write SHALL be accepted in a cycle iff i_valid && o_ready; a read SHALL complete in a cycle iff o_valid && i_ready.
REQ-016 o_ready SHALL be 1 iff o_count < DEPTH and reset is not asserted; total capacity SHALL be exactly DEPTH words.
REQ-017 First-word-fall-through: a word accepted in cycle N into an empty FIFO SHALL appear with o_valid=1 in cycle N+2; there is no combinational input-to-output bypass.
REQ-018 While o_valid && !i_ready, o_valid and o_data SHALL hold stable until the read completes.
REQ-019 Words SHALL be output in acceptance order with no loss, duplication or corruption.
REQ-020 With i_ready held high and the FIFO non-empty, the FIFO SHALL sustain one read per cycle; with o_ready high, it SHALL sustain one write per cycle.
REQ-021 o_count SHALL be registered: +1 on write only, -1 on read only, unchanged on simultaneous write and read or on neither.
REQ-022 Write and read pointers SHALL be ADDR_WIDTH bits and wrap modulo DEPTH with no gap or skipped entry.
REQ-023 When full (o_count == DEPTH), a simultaneous read SHALL NOT allow a same-cycle write; o_ready rises the cycle after the read.
REQ-024 When o_count == 1 and the read completes in the same cycle as a write, o_valid SHALL drop for exactly 1 cycle (the refill RAM latency) and then present the new word.
REQ-025 Writes when o_ready=0 and reads when o_valid=0 SHALL be ignored with no state change.
REQ-026 o_almost_full SHALL be registered and consistent with o_count in the same cycle.

Reset
REQ-027 While i_reset=1 at a rising edge: pointers, o_count and o_valid SHALL be 0, o_ready SHALL be 0 and o_almost_full SHALL be 0, and o_data SHALL be all zeros.
REQ-028 In the first cycle after i_reset deasserts, o_ready SHALL be 1; RAM contents are not cleared, and stale entries SHALL never be presented.
REQ-029 Reset asserted mid-operation SHALL discard all stored and in-flight words; no pre-reset word SHALL appear after reset.

Verification
REQ-030 Bench SHALL cover: post-reset write of 0xA5A5A5A5 in cycle 0 with i_ready=1 -> o_valid=1, o_data=0xA5A5A5A5 in cycle 2, and o_count returns to 0 after the read.
REQ-031 Bench SHALL cover: with i_ready=0, write 32 words 0..31 (defaults) -> o_count=32, o_ready=0, o_almost_full high from o_count=28; then i_ready=1 -> words 0..31 in order, one per cycle after the first.
REQ-032 Bench SHALL cover: full FIFO with i_valid=1 and a read in the same cycle -> no write accepted that cycle; o_count=31 next cycle, o_ready=1.
REQ-033 Bench SHALL cover: o_valid=1 with i_ready toggling randomly for 200 cycles -> o_data never changes while stalled, and the sequence matches the reference model.
REQ-034 Bench SHALL cover: 3 pointer wraps with random valid/ready at 50% duty -> no loss or reorder, and o_count matches the model every cycle.
REQ-035 Bench SHALL cover: i_reset asserted with o_count=10 -> next cycle o_count=0, o_valid=0; after release, the first output equals the first post-reset write.
